exec_unit: RTL

// - Execute stage sitting between the register file read ports and its write port.
// - Takes an opcode plus the operands read from sr1/sr2 (and an immediate) and computes an ALU result.
// - Presents that result as rd/we/data for register-file writeback and keeps a Z/C/N flag register.
// - Single-cycle ops for logic/arith/shift; iterative shift-add multiplier; valid/ready handshake on the input side.

---
 rtl/exec_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute stage: single-cycle ALU, iterative shift-add multiplier, Z/C/N flags
module exec_unit #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clka,
    input  logic             reset_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0]       opcode_in,
    input  logic [WIDTH-1:0] sr1_data_in,
    input  logic [WIDTH-1:0] sr2_data_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [AW-1:0]    rd_in,
    output logic             we_reg_out,
    output logic [AW-1:0]    rd_out,
    output logic [WIDTH-1:0] data_out,
    output logic [2:0]       flags_out,
    output logic             busy_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                           OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
                           OP_MUL = 4'h8, OP_MOV = 4'h9, OP_LDI = 4'hA, OP_CMP = 4'hB;

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        rd_q, rd_d, mrd_q, mrd_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [2:0]           flags_q, flags_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic [WIDTH:0]       sum_ext, diff_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_write, alu_def;
    logic [2*WIDTH-1:0]   acc_step;

    assign ready_out  = (state_q != S_MUL);
    assign busy_out   = (state_q == S_MUL);
    assign accept     = valid_in & ready_out;
    assign we_reg_out = we_q;
    assign rd_out     = rd_q;
    assign data_out   = data_q;
    assign flags_out  = flags_q;

    assign sum_ext  = {1'b0, sr1_data_in} + {1'b0, sr2_data_in};
    assign diff_ext = {1'b0, sr1_data_in} - {1'b0, sr2_data_in};
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_write = 1'b1;
        alu_def   = 1'b1;
        case (opcode_in)
            OP_ADD: begin alu_res = sum_ext[WIDTH-1:0];  alu_c = sum_ext[WIDTH];  end
            OP_SUB: begin alu_res = diff_ext[WIDTH-1:0]; alu_c = diff_ext[WIDTH]; end
            OP_AND: alu_res = sr1_data_in & sr2_data_in;
            OP_OR:  alu_res = sr1_data_in | sr2_data_in;
            OP_XOR: alu_res = sr1_data_in ^ sr2_data_in;
            OP_NOT: alu_res = ~sr1_data_in;
            OP_SHL: begin alu_res = {sr1_data_in[WIDTH-2:0], 1'b0}; alu_c = sr1_data_in[WIDTH-1]; end
            OP_SHR: begin alu_res = {1'b0, sr1_data_in[WIDTH-1:1]}; alu_c = sr1_data_in[0]; end
            OP_MOV: alu_res = sr1_data_in;
            OP_LDI: alu_res = imm_in;
            OP_CMP: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_c     = diff_ext[WIDTH];
                alu_write = 1'b0;
            end
            default: begin
                // MUL is handled by the FSM; C-F are consumed silently
                alu_write = 1'b0;
                alu_def   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        rd_d     = rd_q;
        mrd_d    = mrd_q;
        data_d   = data_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_WB;
                    we_d    = 1'b1;
                    rd_d    = mrd_q;
                    data_d  = acc_step[WIDTH-1:0];
                    flags_d = {acc_step[WIDTH-1:0] == '0,
                               acc_step[2*WIDTH-1:WIDTH] != '0,
                               acc_step[WIDTH-1]};
                end
            end
            default: begin
                if (accept) begin
                    if (opcode_in == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, sr1_data_in};
                        mplier_d = sr2_data_in;
                        // rd_out keeps showing the previous result until the product lands
                        mrd_d    = rd_in;
                    end else begin
                        state_d = S_WB;
                        if (alu_write) begin
                            we_d   = 1'b1;
                            rd_d   = rd_in;
                            data_d = alu_res;
                        end
                        if (alu_def)
                            flags_d = {alu_res == '0, alu_c, alu_res[WIDTH-1]};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            rd_q     <= '0;
            mrd_q    <= '0;
            data_q   <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            mrd_q    <= mrd_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
